// File: rtl/rs_scheduler_age_if.sv
`default_nettype none
// ============================================================================
//  Module      : rs_scheduler_age_if
//  Description : Dispatch / wakeup / issue / flush bundle between the
//                reservation-station scheduler and its environment.
//                slave  = scheduler side, master = pipeline / driver side.
//  Revision    : 1.0  initial release
// ============================================================================
interface rs_scheduler_age_if #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_FUS    = 4,
    parameter int PAYLOAD_W  = 32
);
    localparam int c_TAGS  = RS_ENTRIES * NUM_FUS;
    localparam int c_TAG_W = $clog2(c_TAGS);
    localparam int c_IDX_W = $clog2(RS_ENTRIES);
    localparam int c_OCC_W = c_IDX_W + 1;

    logic                  disp_valid;
    logic                  disp_ready;
    logic [c_TAGS-1:0]     disp_dep_mask;
    logic [PAYLOAD_W-1:0]  disp_payload;
    logic [c_TAG_W-1:0]    disp_tag;
    logic [c_TAGS-1:0]     wakeup_mask;
    logic                  issue_valid;
    logic                  issue_ready;
    logic [c_IDX_W-1:0]    issue_idx;
    logic [PAYLOAD_W-1:0]  issue_payload;
    logic [RS_ENTRIES-1:0] local_ready_mask;
    logic                  flush;
    logic [c_OCC_W-1:0]    occupancy;

    modport slave (
        input  disp_valid, disp_dep_mask, disp_payload, wakeup_mask,
               issue_ready, flush,
        output disp_ready, disp_tag, issue_valid, issue_idx, issue_payload,
               local_ready_mask, occupancy
    );

    modport master (
        output disp_valid, disp_dep_mask, disp_payload, wakeup_mask,
               issue_ready, flush,
        input  disp_ready, disp_tag, issue_valid, issue_idx, issue_payload,
               local_ready_mask, occupancy
    );
endinterface
`default_nettype wire

// File: rtl/rs_scheduler_age.sv
`default_nettype none
// ============================================================================
//  Module      : rs_scheduler_age
//  Description : Single reservation station feeding one functional unit.
//                Tracks per-entry dependency masks over the global tag space,
//                wakes entries from a completion broadcast (with same-cycle
//                bypass at dispatch), supports flush, and selects one ready
//                entry per cycle for register read.
//  Options     : SCHED_AGE_ORDER_EN - when defined, an age matrix is kept and
//                select is oldest-ready-first; otherwise select is the
//                lowest-index ready entry.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_scheduler_age #(
    parameter int RS_ENTRIES = 8,
    parameter int NUM_FUS    = 4,
    parameter int FU_ID      = 0,
    parameter int PAYLOAD_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    rs_scheduler_age_if.slave  bus
);
    localparam int c_TAGS  = RS_ENTRIES * NUM_FUS;
    localparam int c_TAG_W = $clog2(c_TAGS);
    localparam int c_IDX_W = $clog2(RS_ENTRIES);
    localparam int c_OCC_W = c_IDX_W + 1;

    // Global tag of slot 0; slot i owns tag c_TAG_BASE + i.
    localparam logic [c_TAG_W-1:0] c_TAG_BASE = c_TAG_W'(FU_ID * RS_ENTRIES);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [RS_ENTRIES-1:0] r_valid;
    logic [c_TAGS-1:0]     r_dep     [RS_ENTRIES];
    logic [PAYLOAD_W-1:0]  r_payload [RS_ENTRIES];

    logic [RS_ENTRIES-1:0] w_ready;
    logic [RS_ENTRIES-1:0] w_sel_onehot;
    logic [c_IDX_W-1:0]    w_sel_idx;
    logic                  w_any_ready;
    logic                  w_has_free;
    logic [c_IDX_W-1:0]    w_free_idx;
    logic [c_OCC_W-1:0]    w_occ;
    logic                  w_disp_ready;
    logic                  w_disp_fire;
    logic                  w_issue_fire;

    // An entry is ready when it holds an instruction whose dependencies
    // have all been seen on the completion broadcast.
    generate
        for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_ready
            assign w_ready[gi] = r_valid[gi] && (r_dep[gi] == '0);
        end
    endgenerate

    assign w_any_ready = |w_ready;

    // Lowest-index free slot receives the next dispatch.
    always_comb begin
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_has_free = 1'b1;
                w_free_idx = c_IDX_W'(i);
            end
        end
    end

    // Occupancy is the population count of valid entries.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_occ = w_occ + c_OCC_W'(r_valid[i]);
        end
    end

    // A free slot exists exactly when occupancy is below capacity; flush
    // blocks new work in its own cycle, and a same-cycle issue is not
    // counted as freeing a slot.
    assign w_disp_ready = w_has_free && !bus.flush;
    assign w_disp_fire  = bus.disp_valid && w_disp_ready;
    assign w_issue_fire = w_any_ready && bus.issue_ready && !bus.flush;

`ifdef SCHED_AGE_ORDER_EN
    // ------------------------------------------------------------------
    // Age matrix: r_age[i][j] = 1 means entry i is older than entry j.
    // Every pair of valid entries is ordered because the younger one set
    // its column against all entries valid at its dispatch.
    // ------------------------------------------------------------------
    logic [RS_ENTRIES-1:0] r_age [RS_ENTRIES];

    // On dispatch to slot k: k is younger than every currently valid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_age[i] <= '0;
            end
        end else if (w_disp_fire) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                for (int j = 0; j < RS_ENTRIES; j++) begin
                    if (w_free_idx == c_IDX_W'(i)) begin
                        r_age[i][j] <= 1'b0;
                    end else if (w_free_idx == c_IDX_W'(j)) begin
                        r_age[i][j] <= r_valid[i];
                    end
                end
            end
        end
    end

    // Pick the ready entry that no other ready entry is older than.
    always_comb begin
        w_sel_onehot = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_sel_onehot[i] = w_ready[i];
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if ((j != i) && w_ready[j] && r_age[j][i]) begin
                    w_sel_onehot[i] = 1'b0;
                end
            end
        end
    end
`else
    // Fixed priority: the lowest-index ready entry wins.
    always_comb begin
        w_sel_onehot = '0;
        for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel_onehot    = '0;
                w_sel_onehot[i] = 1'b1;
            end
        end
    end
`endif

    // One-hot selection to slot index; zero when nothing is ready.
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (w_sel_onehot[i]) begin
                w_sel_idx = c_IDX_W'(i);
            end
        end
    end

    // Valid bits and dependency masks: flush empties the station, issue
    // frees the selected slot, dispatch fills the free slot, and every
    // completion broadcast clears matching dependency bits (including the
    // one arriving alongside a dispatch).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_dep[i] <= '0;
            end
        end else if (bus.flush) begin
            r_valid <= '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_dep[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_disp_fire && (w_free_idx == c_IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_dep[i]   <= bus.disp_dep_mask & ~bus.wakeup_mask;
                end else begin
                    if (w_issue_fire && (w_sel_idx == c_IDX_W'(i))) begin
                        r_valid[i] <= 1'b0;
                    end
                    r_dep[i] <= r_dep[i] & ~bus.wakeup_mask;
                end
            end
        end
    end

    // Payload storage is captured at dispatch and otherwise held.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                r_payload[i] <= '0;
            end
        end else if (w_disp_fire) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_free_idx == c_IDX_W'(i)) begin
                    r_payload[i] <= bus.disp_payload;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (combinational from state; selection is stable while the
    // state does not change)
    // ------------------------------------------------------------------
    assign bus.disp_ready       = w_disp_ready;
    assign bus.disp_tag         = c_TAG_BASE + c_TAG_W'(w_free_idx);
    assign bus.issue_valid      = w_any_ready;
    assign bus.issue_idx        = w_sel_idx;
    assign bus.issue_payload    = w_any_ready ? r_payload[w_sel_idx] : '0;
    assign bus.local_ready_mask = w_ready;
    assign bus.occupancy        = w_occ;

endmodule
`default_nettype wire

// File: doc/rs_scheduler_age.md
Name: rs_scheduler_age

Overview:
- Parametrised successor to the single-FU scheduler: one reservation station of RS_ENTRIES slots feeding one functional unit (FU_ID) out of NUM_FUS.
- Tracks per-entry dependency masks over the global tag space (RS_ENTRIES*NUM_FUS), wakes entries from a global completion mask, and selects one ready entry per cycle for register read.
- New relative to the prior scheduler: age-ordered selection, same-cycle wakeup bypass at dispatch, flush, and a payload field.

Parameters:
- RS_ENTRIES, 8, slots in this station (power of two, ≥2)
- NUM_FUS, 4, functional units sharing the global tag space
- FU_ID, 0, index of this station's FU; global tag of slot i = FU_ID*RS_ENTRIES + i
- PAYLOAD_W, 32, opaque per-entry payload width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept a dispatch this cycle
- disp_dep_mask  in  RS_ENTRIES*NUM_FUS  global tags the instruction waits on
- disp_payload  in  PAYLOAD_W  opaque payload
- disp_tag  out  $clog2(RS_ENTRIES*NUM_FUS)  global tag assigned to the accepted dispatch
- wakeup_mask  in  RS_ENTRIES*NUM_FUS  completion broadcast, one-cycle pulses per tag
- issue_valid  out  1  a ready entry is selected
- issue_ready  in  1  register read accepts the selection
- issue_idx  out  $clog2(RS_ENTRIES)  selected slot
- issue_payload  out  PAYLOAD_W  payload of the selected slot
- local_ready_mask  out  RS_ENTRIES  valid entries with all dependencies cleared
- flush  in  1  discard all entries
- occupancy  out  $clog2(RS_ENTRIES)+1  number of valid entries

Behaviour:
- Reset (sync, rst=1 at posedge): all entry_valid=0, dep masks=0, age matrix=0. Outputs: disp_ready=1, issue_valid=0, issue_idx=0, issue_payload=0, local_ready_mask=0, occupancy=0, disp_tag=FU_ID*RS_ENTRIES.
- Allocation: free slot = lowest-index invalid entry. disp_ready = (occupancy < RS_ENTRIES) && !flush. disp_tag is combinational from the free slot.
- Dispatch: on disp_valid && disp_ready, the slot becomes valid next cycle with dep_mask = disp_dep_mask & ~wakeup_mask (same-cycle bypass).
- Wakeup: every cycle, each valid entry's dep_mask &= ~wakeup_mask. local_ready_mask[i] = valid[i] && dep_mask[i]==0, computed from registered state. A dispatch with all deps cleared is therefore ready the cycle after dispatch.
- Select: issue_valid = |local_ready_mask. issue_idx is the oldest ready entry per the age matrix (age[i][j]=1 means i older than j). On dispatch to slot k: row k cleared, column k set for all currently valid entries. Outputs are combinational from state.
- Issue handshake: on issue_valid && issue_ready, slot issue_idx is invalidated next cycle. If issue_ready=0, the selection holds stably (no re-arbitration while the state is unchanged). A freed slot cannot be reallocated in the same cycle it issues; disp_ready does not count a same-cycle issue.
- Simultaneous dispatch+issue: both take effect; occupancy is unchanged.
- Full: occupancy==RS_ENTRIES gives disp_ready=0; disp_valid is ignored.
- Flush: next cycle all entries are invalid and occupancy=0. Dispatch is blocked and any issue handshake is ignored in the flush cycle. Flush has no priority over rst; rst wins.
- Wakeup bits for tags no entry depends on have no effect. A wakeup of the station's own tags is legal.

Optional Feature:
- SCHED_AGE_ORDER_EN. When defined: the age matrix is built and select is oldest-first, as above.
- When undefined: no age matrix. Select is the lowest-index ready entry (fixed priority). All other behaviour is identical.

Test Plan:
- Reset, then dispatch 3 entries with dep_mask=0 -> disp_tag 0,1,2 (FU_ID=0); after one cycle local_ready_mask=0b111, issue_idx=0; occupancy=3.
- Dispatch slot0 dep=tag9, slot1 dep=0; pulse wakeup_mask bit9 -> slot1 issues first, then slot0 is ready the next cycle (age order: slot0 issues before any later dispatch).
- Fill all 8 slots -> disp_ready=0, a 9th disp_valid is ignored; issue one with issue_ready=1 -> disp_ready=1 the following cycle, new disp_tag equals the freed index.
- Dispatch dep=tag5 in the same cycle wakeup_mask bit5=1 -> entry is ready the next cycle (bypass).
- Hold issue_ready=0 for 3 cycles with 2 ready entries -> issue_idx and issue_payload stable; release -> the older one issues.
- Occupancy 5, assert flush together with disp_valid -> next cycle occupancy=0, issue_valid=0, no entry allocated; rst asserted mid-stream -> all outputs return to reset values.
